// File: rtl/timer_svc_pkg.sv
// rtl/timer_svc_pkg.sv - shared types and register map for the timer IRQ service master
package timer_svc_pkg;

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_INIT_RD,
        ST_IDLE,
        ST_RESYNC,
        ST_ACK,
        ST_STAT_RD,
        ST_CHK,
        ST_ERROR
    } svc_state_e;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam int STATUS_TO   = 0;
    localparam int CONTROL_ITO = 0;

    localparam logic [15:0] CTRL_ITO_VAL = 16'h0001 << CONTROL_ITO;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } avm_cmd_t;

    // Bus access issued while the FSM sits in state s; non-bus states yield an idle bus.
    function automatic avm_cmd_t bus_cmd(svc_state_e s);
        avm_cmd_t c;
        c.cs      = 1'b0;
        c.write_n = 1'b1;
        c.addr    = ADDR_STATUS;
        c.wdata   = 16'h0000;
        case (s)
            ST_INIT_WR: begin
                c.cs      = 1'b1;
                c.write_n = 1'b0;
                c.addr    = ADDR_CONTROL;
                c.wdata   = CTRL_ITO_VAL;
            end
            ST_INIT_RD: begin
                c.cs   = 1'b1;
                c.addr = ADDR_CONTROL;
            end
            ST_RESYNC: begin
                c.cs      = 1'b1;
                c.write_n = 1'b0;
                c.addr    = ADDR_PERIODL;
            end
            ST_ACK: begin
                c.cs      = 1'b1;
                c.write_n = 1'b0;
                c.addr    = ADDR_STATUS;
            end
            ST_STAT_RD: begin
                c.cs   = 1'b1;
                c.addr = ADDR_STATUS;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/timer_irq_service_master.sv
// rtl/timer_irq_service_master.sv - Avalon-MM initiator that initialises and services a 16-bit interval timer
module timer_irq_service_master
    import timer_svc_pkg::*;
#(
    parameter int TICK_W     = 32,
    parameter int OVR_W      = 8,
    parameter int RD_LATENCY = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              resync_req,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [OVR_W-1:0]  overrun_count,
    output logic              busy,
    output logic              error
);

    localparam int LAT_W   = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    svc_state_e          state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RETRY_W-1:0]  retry_inc;
    logic                pend_q, pend_d;
    logic                rd_to_q, rd_to_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [OVR_W-1:0]    ovr_q, ovr_d;
    avm_cmd_t            bus_q, bus_d;
    logic                lat_done;
    logic                rd_state_d;
    logic                rd_state_q;

    assign lat_done   = (lat_q == '0);
    assign retry_inc  = retry_q + 1'b1;
    assign rd_state_q = (state_q == ST_INIT_RD) || (state_q == ST_STAT_RD);
    assign rd_state_d = (state_d == ST_INIT_RD) || (state_d == ST_STAT_RD);

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        pend_d     = pend_q;
        rd_to_d    = rd_to_q;
        tick_cnt_d = tick_cnt_q;
        ovr_d      = ovr_q;

        case (state_q)
            // The bus register lags the state by design, so the first cycle out of
            // reset holds here until the control write is actually on the bus.
            ST_INIT_WR: begin
                if (bus_q.cs && !bus_q.write_n) begin
                    state_d = ST_INIT_RD;
                end
            end
            ST_INIT_RD: begin
                if (lat_done) begin
                    if (avm_readdata[CONTROL_ITO]) begin
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_ERROR : ST_INIT_WR;
                    end
                end
            end
            ST_IDLE: begin
                if (enable && irq) begin
                    state_d = ST_ACK;
                end else if (pend_q) begin
                    state_d = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ACK: begin
                state_d = ST_STAT_RD;
            end
            ST_STAT_RD: begin
                if (lat_done) begin
                    rd_to_d = avm_readdata[STATUS_TO];
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                tick_cnt_d = tick_cnt_q + 1'b1;
                if (rd_to_q) begin
                    if (ovr_q != '1) begin
                        ovr_d = ovr_q + 1'b1;
                    end
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_INIT_WR;
            end
        endcase

        if (resync_req && (state_q != ST_ERROR)) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        lat_d = lat_q;
        if (rd_state_d && (state_d != state_q)) begin
            lat_d = LAT_W'(RD_LATENCY);
        end else if (rd_state_q && !lat_done) begin
            lat_d = lat_q - 1'b1;
        end
    end

    // Registering the decode of the next state keeps the bus glitch-free and lets
    // the asynchronous reset drop the bus to idle immediately.
    assign bus_d = bus_cmd(state_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT_WR;
            lat_q      <= '0;
            retry_q    <= '0;
            pend_q     <= 1'b0;
            rd_to_q    <= 1'b0;
            tick_cnt_q <= '0;
            ovr_q      <= '0;
            bus_q      <= '{cs: 1'b0, write_n: 1'b1, addr: ADDR_STATUS, wdata: 16'h0000};
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            retry_q    <= retry_d;
            pend_q     <= pend_d;
            rd_to_q    <= rd_to_d;
            tick_cnt_q <= tick_cnt_d;
            ovr_q      <= ovr_d;
            bus_q      <= bus_d;
        end
    end

    assign avm_chipselect = bus_q.cs;
    assign avm_write_n    = bus_q.write_n;
    assign avm_address    = bus_q.addr;
    assign avm_writedata  = bus_q.wdata;
    assign tick           = (state_q == ST_CHK);
    assign tick_count     = tick_cnt_q;
    assign overrun_count  = ovr_q;
    assign busy           = (state_q != ST_IDLE);
    assign error          = (state_q == ST_ERROR);

endmodule

// File: tb/tb_timer_irq_service_master.sv
// tb/tb_timer_irq_service_master.sv - randomized self-checking bench with a behavioural timer slave
module tb_timer_irq_service_master;

    localparam int TICK_W  = 4;
    localparam int OVR_W   = 3;
    localparam int OVR_MAX = 7;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic              resync_req;
    logic [2:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [15:0]       avm_writedata;
    logic [15:0]       avm_readdata;
    logic              irq;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic [OVR_W-1:0]  overrun_count;
    logic              busy;
    logic              error;

    timer_irq_service_master #(
        .TICK_W(TICK_W), .OVR_W(OVR_W), .RD_LATENCY(1), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .resync_req(resync_req),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .irq(irq), .tick(tick),
        .tick_count(tick_count), .overrun_count(overrun_count),
        .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural interval-timer slave: TO flag, control register, registered readdata.
    logic       to_q;
    logic [15:0] ctrl_q;
    logic       to_req;
    logic       force_ctrl_zero;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q         <= 1'b0;
            ctrl_q       <= 16'h0000;
            avm_readdata <= 16'h0000;
        end else begin
            if (avm_chipselect && !avm_write_n && avm_address == 3'd0) to_q <= 1'b0;
            if (avm_chipselect && !avm_write_n && avm_address == 3'd1) ctrl_q <= avm_writedata;
            if (to_req) to_q <= 1'b1;
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    3'd0:    avm_readdata <= {15'($urandom), to_q};
                    3'd1:    avm_readdata <= force_ctrl_zero ? 16'h0000 : ctrl_q;
                    default: avm_readdata <= 16'($urandom);
                endcase
            end
        end
    end

    assign irq = to_q & ctrl_q[0];

    logic [18:0] wlog[$];
    int          tick_seen;
    initial tick_seen = 0;

    always @(negedge clk) begin
        if (reset_n && avm_chipselect && !avm_write_n) wlog.push_back({avm_address, avm_writedata});
        if (reset_n && tick) tick_seen++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ticks = 0;
    int exp_ovr   = 0;
    int exp_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] d);
        return {11'd0, cs, wn, a, d};
    endfunction

    function automatic logic [31:0] bus_word();
        return mk(avm_chipselect, avm_write_n, avm_address, avm_writedata);
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check(tag, {31'd0, busy}, 32'd0);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd1);
    endtask

    task automatic inject_timeout();
        @(negedge clk);
        to_req = 1'b1;
        @(posedge clk);
        #1 to_req = 1'b0;
    endtask

    // One serviced timeout from IDLE; ov re-raises TO right after the clear write.
    task automatic serve(input bit ov);
        logic [31:0] s[4];
        int lat = -1;
        for (int i = 0; i < 4; i++) s[i] = '0;
        inject_timeout();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 4) s[c] = bus_word();
            if (ov && c == 1) to_req = 1'b1;
            if (ov && c == 2) to_req = 1'b0;
            if (tick) begin
                lat = c;
                break;
            end
        end
        to_req = 1'b0;
        check("irq_to_tick_latency", lat, 32'd4);
        check("idle_before_ack", s[0], mk(1'b0, 1'b1, 3'd0, 16'h0000));
        check("ack_write", s[1], mk(1'b1, 1'b0, 3'd0, 16'h0000));
        check("status_read_1", s[2], mk(1'b1, 1'b1, 3'd0, 16'h0000));
        check("status_read_2", s[3], mk(1'b1, 1'b1, 3'd0, 16'h0000));
        wait_idle("service_idle");
        exp_ticks  += ov ? 2 : 1;
        exp_pulses += ov ? 2 : 1;
        if (ov && exp_ovr < OVR_MAX) exp_ovr++;
        check("tick_count", 32'(tick_count), 32'(exp_ticks % (1 << TICK_W)));
        check("overrun_count", 32'(overrun_count), 32'(exp_ovr));
    endtask

    initial begin
        logic [31:0] init_s[5];
        logic        busy_s[5];
        int          n;
        int          n_ctrl_wr;
        int          n_cs;

        reset_n = 1'b0; enable = 1'b1; resync_req = 1'b0; to_req = 1'b0; force_ctrl_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", bus_word(), mk(1'b0, 1'b1, 3'd0, 16'h0000));
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_tick_count", 32'(tick_count), 32'd0);
        check("rst_overrun", 32'(overrun_count), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_error", {31'd0, error}, 32'd0);

        reset_n = 1'b1;
        #1 wlog.delete();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            init_s[k] = bus_word();
            busy_s[k] = busy;
        end
        check("init_write", init_s[1], mk(1'b1, 1'b0, 3'd1, 16'h0001));
        check("init_read_1", init_s[2], mk(1'b1, 1'b1, 3'd1, 16'h0000));
        check("init_read_2", init_s[3], mk(1'b1, 1'b1, 3'd1, 16'h0000));
        check("init_bus_idle", init_s[4], mk(1'b0, 1'b1, 3'd0, 16'h0000));
        check("init_busy_c3", {31'd0, busy_s[3]}, 32'd1);
        check("init_busy_c4", {31'd0, busy_s[4]}, 32'd0);

        serve(1'b0);
        serve(1'b1);

        // enable low: a pending irq must be ignored while IDLE
        @(negedge clk);
        enable = 1'b0;
        #1 wlog.delete();
        inject_timeout();
        repeat (6) @(negedge clk);
        #1;
        check("disabled_busy", {31'd0, busy}, 32'd0);
        check("disabled_no_writes", wlog.size(), 32'd0);
        enable = 1'b1;
        wait_busy("enable_resume");
        wait_idle("enable_service_idle");
        exp_ticks++; exp_pulses++;
        check("enable_tick_count", 32'(tick_count), 32'(exp_ticks % (1 << TICK_W)));

        // three resync pulses, the first coinciding with irq in IDLE
        #1 wlog.delete();
        inject_timeout();
        @(negedge clk); resync_req = 1'b1;
        @(negedge clk); resync_req = 1'b0;
        @(negedge clk); resync_req = 1'b1;
        @(negedge clk); resync_req = 1'b0;
        @(negedge clk); resync_req = 1'b1;
        @(negedge clk); resync_req = 1'b0;
        wait_idle("resync_svc_idle");
        repeat (4) @(negedge clk);
        wait_idle("resync_idle");
        exp_ticks++; exp_pulses++;
        check("resync_write_count", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            check("resync_first_is_clear", {13'd0, wlog[0]}, {13'd0, 3'd0, 16'h0000});
            check("resync_then_periodl", {13'd0, wlog[1]}, {13'd0, 3'd2, 16'h0000});
        end

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            serve((i < 9) || ($urandom_range(0, 1) == 1));
        end
        check("tick_pulses", tick_seen, exp_pulses);

        // reset in the middle of a status read
        inject_timeout();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_chipselect && avm_write_n && avm_address == 3'd0) && n < 20);
        check("reached_status_read", {31'd0, avm_chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_cs", {31'd0, avm_chipselect}, 32'd0);
        check("midreset_tick_count", 32'(tick_count), 32'd0);
        check("midreset_overrun", 32'(overrun_count), 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        #1 wlog.delete();
        wait_idle("reinit_idle");
        check("reinit_writes", wlog.size(), 32'd1);
        if (wlog.size() >= 1) check("reinit_ctrl_write", {13'd0, wlog[0]}, {13'd0, 3'd1, 16'h0001});

        // control readback stuck at zero
        force_ctrl_zero = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 wlog.delete();
        n = 0;
        while (!error && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("error_set", {31'd0, error}, 32'd1);
        n_cs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            resync_req = (k == 2);
            if (avm_chipselect) n_cs++;
        end
        resync_req = 1'b0;
        #1;
        n_ctrl_wr = 0;
        foreach (wlog[i]) if (wlog[i][18:16] == 3'd1) n_ctrl_wr++;
        check("error_ctrl_writes", n_ctrl_wr, 32'd3);
        check("error_bus_idle", n_cs, 32'd0);
        check("error_busy", {31'd0, busy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
